avl_req_bridge: RTL and testbench

- Sits between CreekCore and the fpga_ddr3 controller's Avalon-MM local interface.
- Accepts single-beat load/store requests from the core over a valid/ready handshake and converts them into Avalon commands that obey avl_ready backpressure.
- Tracks read credits so every read issued has a guaranteed slot in an internal response FIFO. This is required because avl_readdatavalid cannot be stalled.
- Returns read data to the core in issue order.

---
 rtl/creek_mem_pkg.sv | 21 ++
 rtl/resp_fifo.sv | 51 +++++
 rtl/avl_req_bridge.sv | 136 +++++++++++++
 tb/tb_avl_req_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/creek_mem_pkg.sv
// creek_mem_pkg: shared widths, Avalon constants and bridge FSM states for the CreekCore memory path
package creek_mem_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 128;

    // Every command is a single-beat burst
    localparam logic [2:0] AVL_SIZE_ONE = 3'b001;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        CMD       = 2'd2
    } bridge_state_e;

    // A store never needs a response slot; a load needs one free read credit
    function automatic logic can_issue(input logic init_done, input logic is_write, input logic credit_avail);
        return init_done & (is_write | credit_avail);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: first-word-fall-through FIFO holding read beats until the core takes them
module resp_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a full FIFO can still take a push alongside it
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents are don't-care until written so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/avl_req_bridge.sv
// avl_req_bridge: turns CreekCore single-beat load/store requests into Avalon-MM commands with read-credit flow control
module avl_req_bridge import creek_mem_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RESP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              local_init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_burstbegin,
    output logic [2:0]        avl_size,
    input  logic              avl_ready,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata,
    output logic              idle,
    output logic              err
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;

    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RESP_DEPTH must be a power of two and at least 2");
    end

    bridge_state_e     state_q, state_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic              rd_q, rd_d, wr_q, wr_d, bb_q, bb_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              slot_free, accept, cmd_done, pop, rdv_ok, push;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;

    // The command register is free when nothing is held or the held command is taken this cycle
    assign cmd_done  = state_q == CMD && avl_ready;
    assign slot_free = state_q == IDLE || cmd_done;
    assign req_ready = slot_free & can_issue(local_init_done, req_write, credits_q != '0);
    assign accept    = req_valid & req_ready;

    // Beats are only legitimate while a read is outstanding; the FIFO may be full only if it also pops
    assign pop    = resp_valid & resp_ready;
    assign rdv_ok = avl_readdatavalid & (outstanding_q != '0);
    assign push   = rdv_ok & (~fifo_full | pop);

    // Next state: calibration gates issue, a held command always finishes before leaving CMD
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_INIT: state_d = local_init_done ? IDLE : WAIT_INIT;
            IDLE:      state_d = accept ? CMD : (local_init_done ? IDLE : WAIT_INIT);
            CMD:       state_d = (avl_ready && !accept) ? (local_init_done ? IDLE : WAIT_INIT) : CMD;
            default:   state_d = WAIT_INIT;
        endcase
    end

    // Command registers reload on every accepted request and drop the strobe once the last one is taken
    always_comb begin
        rd_d    = accept ? ~req_write : (cmd_done ? 1'b0 : rd_q);
        wr_d    = accept ? req_write : (cmd_done ? 1'b0 : wr_q);
        bb_d    = rd_d | wr_d;
        addr_d  = accept ? req_addr : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
    end

    // Credits reserve FIFO slots at request time; outstanding counts reads the controller still owes
    always_comb begin
        credits_d     = credits_q - CW'(accept & ~req_write) + CW'(pop);
        outstanding_d = outstanding_q + CW'(rd_q & avl_ready) - CW'(rdv_ok);
        err_d         = err_q | (avl_readdatavalid & ((outstanding_q == '0) | (fifo_full & ~pop)));
    end

    // All bridge state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_INIT;
            credits_q     <= CW'(RESP_DEPTH);
            outstanding_q <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            bb_q          <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            bb_q          <= bb_d;
            err_q         <= err_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (avl_readdata),
        .pop_i       (pop),
        .head_o      (resp_rdata),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign resp_valid     = ~fifo_empty;
    assign avl_address    = addr_q;
    assign avl_read       = rd_q;
    assign avl_write      = wr_q;
    assign avl_writedata  = wdata_q;
    assign avl_burstbegin = bb_q;
    assign avl_size       = AVL_SIZE_ONE;
    assign err            = err_q;
    assign idle           = ~(rd_q | wr_q) & (outstanding_q == '0) & (fifo_count == '0);

endmodule

// File: tb/tb_avl_req_bridge.sv
// tb_avl_req_bridge: directed table, corner-case sequences and randomized traffic against a queue-based model
module tb_avl_req_bridge;

    localparam int AW = 26;
    localparam int DW = 128;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          reset, local_init_done, req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] avl_address;
    logic          avl_read, avl_write, avl_burstbegin;
    logic [DW-1:0] avl_writedata;
    logic [2:0]    avl_size;
    logic          avl_ready, avl_readdatavalid;
    logic [DW-1:0] avl_readdata;
    logic          idle, err;

    avl_req_bridge #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .local_init_done(local_init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_burstbegin(avl_burstbegin), .avl_size(avl_size),
        .avl_ready(avl_ready), .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } pend_t;

    typedef struct {
        bit          init, v, w;
        bit [AW-1:0] a;
        bit          ar, e_rr, e_aw, e_ar;
        bit [AW-1:0] e_a;
        bit          e_idle;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            credits_m, outs_m, lat_min, lat_max;
    bit            inj, chk_rr;
    cmd_t          exp_cmd[$];
    pend_t         pend[$];
    logic [DW-1:0] exp_resp[$];
    vec_t          tbl[11];
    logic [DW-1:0] ord[3];

    logic          s_rr, s_aw, s_ar, s_bb, s_rv, s_idle, s_err;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    function automatic logic [DW-1:0] wd(input logic [AW-1:0] a);
        return {16{8'hA5}} ^ DW'(a) ^ DW'(8'h10);
    endfunction

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return DW'(a) * DW'(8'h11);
    endfunction

    function automatic bit settled(input int nresp);
        return exp_cmd.size() == 0 && outs_m == 0 && exp_resp.size() == nresp;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    // Drive the controller response, then sample outputs just before the coming edge
    task automatic pre();
        if (inj) begin
            avl_readdatavalid = 1'b1;
            avl_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            avl_readdatavalid = 1'b1;
            avl_readdata = rd(pend[0].a);
        end else begin
            avl_readdatavalid = 1'b0;
            avl_readdata = '0;
        end
        #1;
        s_rr = req_ready; s_aw = avl_write; s_ar = avl_read; s_bb = avl_burstbegin;
        s_rv = resp_valid; s_idle = idle; s_err = err;
        s_addr = avl_address; s_wdata = avl_writedata; s_rdata = resp_rdata;
        chk("resp_valid", DW'(s_rv), DW'(exp_resp.size() != 0));
        chk("idle", DW'(s_idle), DW'(exp_cmd.size() == 0 && outs_m == 0 && exp_resp.size() == 0));
        if (chk_rr) begin
            chk("req_ready", DW'(s_rr),
                DW'(local_init_done && (req_write || credits_m != 0) && (exp_cmd.size() == 0 || avl_ready)));
            chk("err_clear", DW'(s_err), '0);
        end
    endtask

    // Cross the edge and advance the model with what happened at it
    task automatic post();
        cmd_t c;
        @(posedge clk);
        if (!reset) begin
            if ((s_aw || s_ar) && avl_ready) begin
                if (exp_cmd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_cmd cyc=%0d got addr=%0h want none", cyc, s_addr);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_write", DW'(s_aw), DW'(c.w));
                    chk("cmd_read", DW'(s_ar), DW'(!c.w));
                    chk("cmd_burstbegin", DW'(s_bb), DW'(1'b1));
                    chk("cmd_addr", DW'(s_addr), DW'(c.a));
                    if (c.w) chk("cmd_wdata", s_wdata, c.d);
                    else begin
                        pend.push_back('{a: c.a, due: cyc + int'($urandom_range(lat_max, lat_min))});
                        outs_m++;
                    end
                end
            end
            if (req_valid && s_rr) begin
                exp_cmd.push_back('{w: req_write, a: req_addr, d: req_wdata});
                if (!req_write) credits_m--;
            end
            if (s_rv && resp_ready) begin
                if (exp_resp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_resp cyc=%0d got=%0h want none", cyc, s_rdata);
                end else chk("resp_data", s_rdata, exp_resp.pop_front());
                credits_m++;
            end
            if (avl_readdatavalid && !inj) begin
                exp_resp.push_back(rd(pend[0].a));
                void'(pend.pop_front());
                outs_m--;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_settled(input int nresp, input string name);
        int k = 0;
        while (!settled(nresp) && k < 100) begin
            pre(); post(); k++;
        end
        checks++;
        if (!settled(nresp)) begin
            failures++;
            $display("FAIL %s timeout got resp=%0d outs=%0d want resp=%0d outs=0", name, exp_resp.size(), outs_m, nresp);
        end
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd(a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1'b0, 1'b1, 1'b1, 26'h10, 1'b1, 1'b0, 1'b0, 1'b0, 26'h00, 1'b1},
            '{1'b1, 1'b1, 1'b1, 26'h10, 1'b1, 1'b0, 1'b0, 1'b0, 26'h00, 1'b1},
            '{1'b1, 1'b1, 1'b1, 26'h10, 1'b1, 1'b1, 1'b0, 1'b0, 26'h00, 1'b1},
            '{1'b1, 1'b1, 1'b1, 26'h20, 1'b0, 1'b0, 1'b1, 1'b0, 26'h10, 1'b0},
            '{1'b1, 1'b1, 1'b1, 26'h20, 1'b0, 1'b0, 1'b1, 1'b0, 26'h10, 1'b0},
            '{1'b1, 1'b1, 1'b1, 26'h20, 1'b0, 1'b0, 1'b1, 1'b0, 26'h10, 1'b0},
            '{1'b1, 1'b1, 1'b1, 26'h20, 1'b0, 1'b0, 1'b1, 1'b0, 26'h10, 1'b0},
            '{1'b1, 1'b1, 1'b1, 26'h20, 1'b0, 1'b0, 1'b1, 1'b0, 26'h10, 1'b0},
            '{1'b1, 1'b1, 1'b1, 26'h20, 1'b1, 1'b1, 1'b1, 1'b0, 26'h10, 1'b0},
            '{1'b1, 1'b0, 1'b1, 26'h00, 1'b1, 1'b1, 1'b1, 1'b0, 26'h20, 1'b0},
            '{1'b1, 1'b0, 1'b1, 26'h00, 1'b1, 1'b1, 1'b0, 1'b0, 26'h20, 1'b1}
        };
        ord = '{DW'(8'h11), DW'(8'h22), DW'(8'h33)};

        reset = 1'b1; local_init_done = 1'b0; issue(1'b1, 26'h10);
        avl_ready = 1'b1; resp_ready = 1'b0; avl_readdatavalid = 1'b0; avl_readdata = '0;
        inj = 1'b0; chk_rr = 1'b0; credits_m = D; outs_m = 0; lat_min = 10; lat_max = 10;

        @(negedge clk); #1;
        chk("rst_req_ready", DW'(req_ready), '0);
        chk("rst_avl_read", DW'(avl_read), '0);
        chk("rst_avl_write", DW'(avl_write), '0);
        chk("rst_burstbegin", DW'(avl_burstbegin), '0);
        chk("rst_idle", DW'(idle), DW'(1'b1));
        chk("rst_resp_valid", DW'(resp_valid), '0);
        chk("rst_err", DW'(err), '0);
        chk("rst_addr", DW'(avl_address), '0);
        chk("rst_wdata", avl_writedata, '0);
        chk("avl_size", DW'(avl_size), DW'(3'b001));
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            local_init_done = tbl[i].init; req_valid = tbl[i].v; req_write = tbl[i].w;
            req_addr = tbl[i].a; req_wdata = wd(tbl[i].a); avl_ready = tbl[i].ar;
            pre();
            chk($sformatf("row%0d_req_ready", i), DW'(s_rr), DW'(tbl[i].e_rr));
            chk($sformatf("row%0d_avl_write", i), DW'(s_aw), DW'(tbl[i].e_aw));
            chk($sformatf("row%0d_avl_read", i), DW'(s_ar), DW'(tbl[i].e_ar));
            chk($sformatf("row%0d_burstbegin", i), DW'(s_bb), DW'(tbl[i].e_aw | tbl[i].e_ar));
            chk($sformatf("row%0d_addr", i), DW'(s_addr), DW'(tbl[i].e_a));
            chk($sformatf("row%0d_idle", i), DW'(s_idle), DW'(tbl[i].e_idle));
            if (tbl[i].e_aw) chk($sformatf("row%0d_wdata", i), s_wdata, wd(tbl[i].e_a));
            post();
        end

        // Read credits run out after RESP_DEPTH loads while stores keep flowing
        avl_ready = 1'b1; resp_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            issue(1'b0, 26'h100 + AW'(i));
            pre(); chk("credit_rd_ready", DW'(s_rr), DW'(1'b1)); post();
        end
        issue(1'b0, 26'h200);
        pre(); chk("credit_block", DW'(s_rr), '0); post();
        issue(1'b1, 26'h300);
        pre(); chk("credit_write_ok", DW'(s_rr), DW'(1'b1)); post();
        req_valid = 1'b0;
        wait_settled(D, "credit_fill");
        issue(1'b0, 26'h200); resp_ready = 1'b1;
        pre(); chk("credit_still_zero", DW'(s_rr), '0); post();
        resp_ready = 1'b0;
        pre(); chk("credit_return", DW'(s_rr), DW'(1'b1)); post();
        req_valid = 1'b0; resp_ready = 1'b1;
        wait_settled(0, "credit_drain");

        // In-order return of three reads
        resp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            issue(1'b0, AW'(i)); pre(); post();
        end
        req_valid = 1'b0;
        wait_settled(3, "order_fill");
        for (int k = 0; k < 3; k++) begin
            resp_ready = 1'b1;
            pre();
            chk("order_valid", DW'(s_rv), DW'(1'b1));
            chk("order_data", s_rdata, ord[k]);
            post();
        end
        resp_ready = 1'b0;
        pre(); chk("order_idle", DW'(s_idle), DW'(1'b1)); post();

        // Unsolicited read beat sets a sticky error and is discarded
        pre(); chk("err_before", DW'(s_err), '0); post();
        inj = 1'b1; pre(); post(); inj = 1'b0;
        pre(); chk("err_set", DW'(s_err), DW'(1'b1)); chk("err_fifo_empty", DW'(s_rv), '0); post();
        repeat (3) begin pre(); post(); end
        pre(); chk("err_sticky", DW'(s_err), DW'(1'b1)); post();

        // Asynchronous reset while a write is held and three reads are outstanding
        lat_min = 20; lat_max = 20; avl_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 26'h40 + AW'(i)); pre(); post();
        end
        issue(1'b1, 26'h50); pre(); post();
        req_valid = 1'b0; avl_ready = 1'b0;
        pre(); chk("rst_mid_held", DW'(s_aw), DW'(1'b1)); post();
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_write", DW'(avl_write), '0);
        chk("rst_mid_read", DW'(avl_read), '0);
        chk("rst_mid_bb", DW'(avl_burstbegin), '0);
        chk("rst_mid_addr", DW'(avl_address), '0);
        chk("rst_mid_wdata", avl_writedata, '0);
        chk("rst_mid_resp_valid", DW'(resp_valid), '0);
        chk("rst_mid_err", DW'(err), '0);
        chk("rst_mid_idle", DW'(idle), DW'(1'b1));
        chk("rst_mid_req_ready", DW'(req_ready), '0);
        exp_cmd.delete(); pend.delete(); exp_resp.delete(); credits_m = D; outs_m = 0;
        @(negedge clk);
        pre(); post();
        reset = 1'b0; local_init_done = 1'b1; avl_ready = 1'b1; issue(1'b0, 26'h5);
        pre(); chk("rst_wait_init", DW'(s_rr), '0); post();
        pre(); chk("rst_ready_again", DW'(s_rr), DW'(1'b1)); post();
        req_valid = 1'b0;

        // Randomized traffic with random controller backpressure and latency
        chk_rr = 1'b1; lat_min = 1; lat_max = 12;
        for (int n = 0; n < 3000; n++) begin
            req_valid = ($urandom() % 4) != 0;
            req_write = ($urandom() % 3) == 0;
            req_addr = AW'($urandom());
            req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            avl_ready = ($urandom() % 4) != 0;
            resp_ready = ($urandom() % 3) != 0;
            pre(); post();
        end
        req_valid = 1'b0; avl_ready = 1'b1; resp_ready = 1'b1;
        wait_settled(0, "final_drain");
        pre(); chk("final_idle", DW'(s_idle), DW'(1'b1)); post();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
